// File: rtl/stream_pack_pkg.sv
// ============================================================================
// Package : stream_pack_pkg
// Brief   : Shared FSM state type and lane-mapping helper for the lane packer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_pack_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  // Maps a beat's arrival index to the physical lane it occupies.
  function automatic int unsigned lane_idx(input int unsigned cnt,
                                           input int unsigned num,
                                           input bit          msb_first);
    return msb_first ? (num - 1 - cnt) : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_lane_outreg.sv
// ============================================================================
// Module : stream_lane_outreg
// Brief  : Output word register with valid/ready hold; optional lane mask
//          (enabled by STREAM_LANE_KEEP_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_lane_outreg #(
  parameter int OUT_W = 32
`ifdef STREAM_LANE_KEEP_EN
  ,
  parameter int NUM   = 4
`endif
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic             last_i,
`ifdef STREAM_LANE_KEEP_EN
  input  logic [NUM-1:0]   keep_i,
  output logic [NUM-1:0]   keep_o,
`endif
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             free_o
);

  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             last_q;
`ifdef STREAM_LANE_KEEP_EN
  logic [NUM-1:0]   keep_q;
`endif

  // A load may coincide with the consumer taking the current word.
  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clock) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef STREAM_LANE_KEEP_EN
      keep_q  <= '0;
`endif
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
`ifdef STREAM_LANE_KEEP_EN
      keep_q  <= keep_i;
`endif
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
`ifdef STREAM_LANE_KEEP_EN
  assign keep_o  = keep_q;
`endif

endmodule

`default_nettype wire

// File: rtl/stream_lane_packer.sv
// ============================================================================
// Module : stream_lane_packer
// Brief  : Packs IN_W-bit beats into IN_W*NUM-bit words; in_last flushes a
//          zero-padded partial word. STREAM_LANE_KEEP_EN adds out_keep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_lane_packer
  import stream_pack_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int NUM       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [IN_W*NUM-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
`ifdef STREAM_LANE_KEEP_EN
  ,
  output logic [NUM-1:0]      out_keep
`endif
);

  localparam int            OUT_W   = IN_W * NUM;
  localparam int            CW      = $clog2(NUM);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM - 1);

  pack_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [CW-1:0]    w_lane;
  logic             w_free;
  logic             w_accept;
  logic             w_complete;
  logic             w_load;
  logic [OUT_W-1:0] w_load_data;
  logic             w_load_last;
`ifdef STREAM_LANE_KEEP_EN
  logic [NUM-1:0]   keep_q;
  logic [NUM-1:0]   keep_d;
  logic [NUM-1:0]   w_load_keep;
`endif

  assign w_lane     = CW'(lane_idx(32'(cnt_q), NUM, MSB_FIRST != 0));
  assign in_ready   = !rst && (state_q == FILL) && ((cnt_q != CNT_MAX) || w_free);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = (cnt_q == CNT_MAX) || in_last;
  assign cnt_d      = cnt_q + CW'(1);

  // Accumulator with the incoming beat merged into its lane.
  always_comb begin
    acc_d = acc_q;
`ifdef STREAM_LANE_KEEP_EN
    keep_d = keep_q;
`endif
    for (int i = 0; i < NUM; i++) begin
      if (w_lane == CW'(i)) begin
        acc_d[i*IN_W +: IN_W] = in_data;
`ifdef STREAM_LANE_KEEP_EN
        keep_d[i] = 1'b1;
`endif
      end
    end
  end

  assign w_load = ((state_q == FILL) && w_accept && w_complete && w_free) ||
                  ((state_q == FLUSH) && w_free);
  assign w_load_data = (state_q == FLUSH) ? acc_q : acc_d;
  assign w_load_last = (state_q == FLUSH) ? 1'b1  : in_last;
`ifdef STREAM_LANE_KEEP_EN
  assign w_load_keep = (state_q == FLUSH) ? keep_q : keep_d;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
`ifdef STREAM_LANE_KEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (w_accept) begin
            if (w_complete && w_free) begin
              cnt_q  <= '0;
              acc_q  <= '0;
`ifdef STREAM_LANE_KEEP_EN
              keep_q <= '0;
`endif
            end else if (w_complete) begin
              // Output still occupied: park the final partial word.
              acc_q   <= acc_d;
              state_q <= FLUSH;
`ifdef STREAM_LANE_KEEP_EN
              keep_q  <= keep_d;
`endif
            end else begin
              acc_q  <= acc_d;
              cnt_q  <= cnt_d;
`ifdef STREAM_LANE_KEEP_EN
              keep_q <= keep_d;
`endif
            end
          end
        end
        FLUSH: begin
          if (w_free) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= FILL;
`ifdef STREAM_LANE_KEEP_EN
            keep_q  <= '0;
`endif
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  stream_lane_outreg #(
    .OUT_W (OUT_W)
`ifdef STREAM_LANE_KEEP_EN
    ,
    .NUM   (NUM)
`endif
  ) u_outreg (
    .clock   (clock),
    .rst     (rst),
    .load_i  (w_load),
    .data_i  (w_load_data),
    .last_i  (w_load_last),
`ifdef STREAM_LANE_KEEP_EN
    .keep_i  (w_load_keep),
    .keep_o  (out_keep),
`endif
    .ready_i (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .last_o  (out_last),
    .free_o  (w_free)
  );

endmodule

`default_nettype wire
